// File: rtl/motor_pi_scheduler.sv
// Closed-loop PI velocity controller shared across NCH motor channels.
// One sample tick every TICK_DIV clocks latches all encoder counters. A
// round-robin sequencer then runs DIFF/INTEG/MULP/MULI/OUT per channel on a
// single multiplier and accumulator.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   enable        run control for the sample-tick generator
//   enc_count     NCH free-running position counters, lane c at [c*CNT_W +: CNT_W]
//   setpoint      NCH signed target velocities (counts per sample)
//   kp, ki        unsigned proportional / integral gains
//   duty          NCH registered unsigned duty words
//   duty_update   one-cycle strobe per lane when its duty word is written
//   sat           integrator of lane c clamped during its last update
//   busy          sequencer is not idle
module motor_pi_scheduler #(
   parameter int unsigned NCH      = 3,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DUTY_W   = 8,
   parameter int unsigned GAIN_W   = 8,
   parameter int unsigned INT_W    = 20,
   parameter int unsigned SHIFT    = 6,
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NCH*CNT_W-1:0]  enc_count,
   input  logic [NCH*CNT_W-1:0]  setpoint,
   input  logic [GAIN_W-1:0]     kp,
   input  logic [GAIN_W-1:0]     ki,
   output logic [NCH*DUTY_W-1:0] duty,
   output logic [NCH-1:0]        duty_update,
   output logic [NCH-1:0]        sat,
   output logic                  busy
);

   localparam int unsigned ACC_W  = GAIN_W + INT_W + 2;
   localparam int unsigned PROD_W = GAIN_W + 1 + INT_W;
   localparam int unsigned TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NCH - 1);

   // Symmetric saturation limits +/-(2^(W-1)-1), one bit wider than the stored value
   localparam logic signed [CNT_W:0] ERR_MAX   = {2'b00, {(CNT_W-1){1'b1}}};
   localparam logic signed [CNT_W:0] ERR_MIN   = {2'b11, {(CNT_W-2){1'b0}}, 1'b1};
   localparam logic signed [INT_W:0] INTEG_MAX = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic signed [INT_W:0] INTEG_MIN = {2'b11, {(INT_W-2){1'b0}}, 1'b1};

   // The sequence must finish before the next tick can arrive
   if (TICK_DIV < 1 + 5*NCH) begin : g_tick_div_check
      $error("motor_pi_scheduler: TICK_DIV must be at least 1+5*NCH");
   end
   if (INT_W < CNT_W) begin : g_int_w_check
      $error("motor_pi_scheduler: INT_W must be at least CNT_W");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_DIFF,
      S_INTEG,
      S_MULP,
      S_MULI,
      S_OUT
   } state_t;

   state_t state, state_nxt;

   logic [TCNT_W-1:0]        tcnt;
   logic                     enable_q;
   logic                     primed;
   logic [CH_W-1:0]          ch;
   logic [CNT_W-1:0]         snap       [NCH];
   logic [CNT_W-1:0]         prev_count [NCH];
   logic signed [INT_W-1:0]  integ      [NCH];
   logic [DUTY_W-1:0]        duty_q     [NCH];
   logic signed [CNT_W-1:0]  err_q;
   logic signed [ACC_W-1:0]  acc;

   logic [CNT_W-1:0]         enc_lane [NCH];
   logic signed [CNT_W-1:0]  sp_lane  [NCH];

   logic                     tick;
   logic                     last_ch;
   logic signed [CNT_W-1:0]  vel;
   logic signed [CNT_W:0]    err_wide;
   logic signed [CNT_W-1:0]  err_sat;
   logic signed [INT_W:0]    integ_sum;
   logic signed [INT_W-1:0]  integ_sat;
   logic                     integ_clamp;
   logic signed [PROD_W-1:0] mul_a;
   logic signed [PROD_W-1:0] mul_b;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  u;
   logic [DUTY_W-1:0]        duty_sat;

   // Unpack lane views of the flat buses
   for (genvar c = 0; c < NCH; c++) begin : g_lane
      assign enc_lane[c]                = enc_count[c*CNT_W +: CNT_W];
      assign sp_lane[c]                 = setpoint[c*CNT_W +: CNT_W];
      assign duty[c*DUTY_W +: DUTY_W]   = duty_q[c];
   end

   assign tick    = enable && (tcnt == TCNT_LAST);
   assign last_ch = (ch == CH_LAST);

   // Per-channel arithmetic for the current sequencer step
   always_comb begin
      vel       = snap[ch] - prev_count[ch];
      err_wide  = {sp_lane[ch][CNT_W-1], sp_lane[ch]} - {vel[CNT_W-1], vel};
      err_sat   = err_wide[CNT_W-1:0];
      if (err_wide > ERR_MAX) begin
         err_sat = ERR_MAX[CNT_W-1:0];
      end else if (err_wide < ERR_MIN) begin
         err_sat = ERR_MIN[CNT_W-1:0];
      end

      integ_sum   = {integ[ch][INT_W-1], integ[ch]}
                  + {{(INT_W-CNT_W+1){err_q[CNT_W-1]}}, err_q};
      integ_sat   = integ_sum[INT_W-1:0];
      integ_clamp = 1'b0;
      if (integ_sum > INTEG_MAX) begin
         integ_sat   = INTEG_MAX[INT_W-1:0];
         integ_clamp = 1'b1;
      end else if (integ_sum < INTEG_MIN) begin
         integ_sat   = INTEG_MIN[INT_W-1:0];
         integ_clamp = 1'b1;
      end

      // Single shared multiplier: kp*err in MULP, ki*integ otherwise
      if (state == S_MULP) begin
         mul_a = PROD_W'(kp);
         mul_b = PROD_W'(err_q);
      end else begin
         mul_a = PROD_W'(ki);
         mul_b = PROD_W'(integ[ch]);
      end
      prod = mul_a * mul_b;

      u        = acc >>> SHIFT;
      duty_sat = u[DUTY_W-1:0];
      if (u[ACC_W-1]) begin
         duty_sat = '0;
      end else if (|u[ACC_W-2:DUTY_W]) begin
         duty_sat = '1;
      end
   end

   // Sequencer next-state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (tick) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = primed ? S_DIFF : S_IDLE;
         S_DIFF:    state_nxt = S_INTEG;
         S_INTEG:   state_nxt = S_MULP;
         S_MULP:    state_nxt = S_MULI;
         S_MULI:    state_nxt = S_OUT;
         S_OUT: begin
            if (!last_ch)  state_nxt = S_DIFF;
            else if (tick) state_nxt = S_CAPTURE;
            else           state_nxt = S_IDLE;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Tick generator, priming flag and per-channel datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt        <= '0;
         enable_q    <= 1'b0;
         primed      <= 1'b0;
         ch          <= '0;
         err_q       <= '0;
         acc         <= '0;
         duty_update <= '0;
         sat         <= '0;
         busy        <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            snap[c]       <= '0;
            prev_count[c] <= '0;
            integ[c]      <= '0;
            duty_q[c]     <= '0;
         end
      end else begin
         enable_q    <= enable;
         busy        <= (state_nxt != S_IDLE);
         duty_update <= '0;

         if (!enable || tick) tcnt <= '0;
         else                 tcnt <= tcnt + TCNT_W'(1);

         // A fresh enable forces a capture-only sequence to avoid a velocity spike
         if (enable && !enable_q)                 primed <= 1'b0;
         else if (state == S_CAPTURE && !primed)  primed <= 1'b1;

         if (state_nxt == S_CAPTURE) begin
            for (int c = 0; c < NCH; c++) snap[c] <= enc_lane[c];
            ch <= '0;
         end

         case (state)
            S_CAPTURE: begin
               if (!primed) begin
                  for (int c = 0; c < NCH; c++) prev_count[c] <= snap[c];
               end
            end
            S_DIFF: begin
               prev_count[ch] <= snap[ch];
               err_q          <= err_sat;
            end
            S_INTEG: begin
               integ[ch] <= integ_sat;
               sat[ch]   <= integ_clamp;
            end
            S_MULP: acc <= ACC_W'(prod);
            S_MULI: acc <= acc + ACC_W'(prod);
            S_OUT: begin
               duty_q[ch]      <= duty_sat;
               duty_update[ch] <= 1'b1;
               if (!last_ch) ch <= ch + CH_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
